// File: rtl/ff_prbs_checker.sv
// PRBS-15 (x^15 + x^14 + 1) checker for the recovered ff_data stream.
// Hunts for lock, then flywheels a local generator and counts bits and errors.
module ff_prbs_checker #(
    parameter int LOCK_CNT   = 64,
    parameter int ERR_WIN    = 128,
    parameter int ERR_THRESH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ff_en,
    input  logic        ff_data,
    input  logic        clear,
    output logic        locked,
    output logic        lost,
    output logic        err_pulse,
    output logic [31:0] bit_cnt,
    output logic [15:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
    localparam int EW = $clog2(ERR_WIN + 1);

    localparam logic [MW-1:0] MATCH_LOCK = MW'(LOCK_CNT);
    localparam logic [WW-1:0] WIN_LAST   = WW'(ERR_WIN - 1);
    localparam logic [EW-1:0] ERR_LIMIT  = EW'(ERR_THRESH);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [14:0]   s;
    logic [3:0]    fill;
    logic [MW-1:0] match;
    logic [WW-1:0] win;
    logic [EW-1:0] werr;

    logic          p;
    logic          in_bit;
    logic          err;
    logic          do_lock;
    logic          do_loss;
    logic [MW-1:0] match_nxt;
    logic [WW-1:0] win_nxt;
    logic [EW-1:0] werr_nxt;

    assign p      = s[13] ^ s[14];
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // HUNT self-seeds from the data; LOCKED feeds the prediction back so the
    // generator free-runs and a burst of errors cannot corrupt its state.
    always_comb begin
        state_nxt = state;
        in_bit    = ff_data;
        err       = 1'b0;
        do_lock   = 1'b0;
        do_loss   = 1'b0;
        match_nxt = match;
        win_nxt   = win;
        werr_nxt  = werr;
        if (ff_en) begin
            if (state == HUNT) begin
                in_bit = ff_data;
                if (fill == 4'd15) begin
                    if ((s == 15'd0) || (ff_data != p)) begin
                        match_nxt = '0;
                    end else begin
                        match_nxt = match + 1'b1;
                    end
                    if (match_nxt == MATCH_LOCK) begin
                        do_lock   = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
            end else begin
                in_bit = p;
                err    = (ff_data != p);
                if (win == WIN_LAST) begin
                    win_nxt  = '0;
                    werr_nxt = EW'(err);
                end else begin
                    win_nxt  = win + 1'b1;
                    werr_nxt = werr + EW'(err);
                end
                if (werr_nxt >= ERR_LIMIT) begin
                    do_loss   = 1'b1;
                    state_nxt = HUNT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s         <= '0;
            fill      <= '0;
            match     <= '0;
            win       <= '0;
            werr      <= '0;
            lost      <= 1'b0;
            err_pulse <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= err;
            if (ff_en) begin
                s <= {s[13:0], in_bit};
                if (state == HUNT) begin
                    if (fill != 4'd15) begin
                        fill <= fill + 1'b1;
                    end
                    match <= match_nxt;
                    if (do_lock) begin
                        win  <= '0;
                        werr <= '0;
                    end
                end else begin
                    if (bit_cnt != 32'hFFFF_FFFF) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (err && (err_cnt != 16'hFFFF)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    win  <= win_nxt;
                    werr <= werr_nxt;
                    if (do_loss) begin
                        lost  <= 1'b1;
                        fill  <= '0;
                        match <= '0;
                    end
                end
            end
            // Placed last so it overrides any same-cycle increment or loss flag.
            if (clear) begin
                bit_cnt <= '0;
                err_cnt <= '0;
                lost    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ff_prbs_checker.sv
// Directed scoreboard bench for ff_prbs_checker driven by a reference PRBS-15 source.
module tb_ff_prbs_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        ff_en;
    logic        ff_data;
    logic        clear;
    logic        locked;
    logic        lost;
    logic        err_pulse;
    logic [31:0] bit_cnt;
    logic [15:0] err_cnt;

    typedef struct {
        string       tag;
        logic        locked;
        logic        lost;
        logic        err_pulse;
        logic [31:0] bit_cnt;
        logic [15:0] err_cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [14:0] gen = 15'h7FFF;

    ff_prbs_checker dut (
        .clk      (clk),
        .reset    (reset),
        .ff_en    (ff_en),
        .ff_data  (ff_data),
        .clear    (clear),
        .locked   (locked),
        .lost     (lost),
        .err_pulse(err_pulse),
        .bit_cnt  (bit_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic next_prbs(output logic b);
        b   = gen[13] ^ gen[14];
        gen = {gen[13:0], b};
    endtask

    task automatic apply_stimulus(input logic en, input logic data, input logic clr);
        ff_en   = en;
        ff_data = data;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_prbs(b);
            apply_stimulus(1'b1, b, 1'b0);
        end
    endtask

    task automatic send_bad(input logic clr);
        logic b;
        next_prbs(b);
        apply_stimulus(1'b1, ~b, clr);
    endtask

    task automatic push_exp(input string tag, input logic l, input logic lo, input logic ep,
                            input logic [31:0] bc, input logic [15:0] ec);
        exp_t e;
        e.tag       = tag;
        e.locked    = l;
        e.lost      = lo;
        e.err_pulse = ep;
        e.bit_cnt   = bc;
        e.err_cnt   = ec;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic check_output();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".locked"},    32'(locked),    32'(e.locked));
            cmp({e.tag, ".lost"},      32'(lost),      32'(e.lost));
            cmp({e.tag, ".err_pulse"}, 32'(err_pulse), 32'(e.err_pulse));
            cmp({e.tag, ".bit_cnt"},   bit_cnt,        e.bit_cnt);
            cmp({e.tag, ".err_cnt"},   32'(err_cnt),   32'(e.err_cnt));
        end
    endtask

    initial begin
        logic b;
        reset   = 1'b0;
        ff_en   = 1'b0;
        ff_data = 1'b0;
        clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_exp("reset_state", 0, 0, 0, 0, 0);
        check_output();
        reset = 1'b1;

        // Clean stream, enabled every cycle: lock lands on enabled bit 79.
        send_clean(78);
        push_exp("pre_lock_78", 0, 0, 0, 0, 0);
        check_output();
        send_clean(1);
        push_exp("lock_at_79", 1, 0, 0, 0, 0);
        check_output();
        for (int i = 1; i <= 10; i++) begin
            send_clean(1);
            push_exp($sformatf("bit_cnt_step%0d", i), 1, 0, 0, 32'(i), 0);
            check_output();
        end

        send_bad(1'b0);
        push_exp("single_err", 1, 0, 1, 11, 1);
        check_output();
        send_clean(1);
        push_exp("after_err", 1, 0, 0, 12, 1);
        check_output();

        // Roll past the first window so the earlier error no longer counts.
        send_clean(118);
        push_exp("window_roll", 1, 0, 0, 130, 1);
        check_output();
        apply_stimulus(1'b0, 1'b1, 1'b1);
        push_exp("clear_idle", 1, 0, 0, 0, 0);
        check_output();

        for (int k = 1; k <= 8; k++) begin
            send_clean(4);
            send_bad(1'b0);
            if (k == 7) push_exp("burst_7th", 1, 0, 1, 35, 7);
            check_output();
        end
        push_exp("burst_8th_loss", 0, 1, 1, 40, 8);
        check_output();

        send_clean(78);
        push_exp("relock_pre", 0, 1, 0, 40, 8);
        check_output();
        send_clean(1);
        push_exp("relock", 1, 1, 0, 40, 8);
        check_output();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        push_exp("clear_lost", 1, 0, 0, 0, 0);
        check_output();

        // Asynchronous reset between clock edges while locked.
        ff_en = 1'b0;
        clear = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        push_exp("async_reset", 0, 0, 0, 0, 0);
        check_output();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Alternating enable with junk data on idle cycles.
        for (int i = 0; i < 78; i++) begin
            next_prbs(b);
            apply_stimulus(1'b1, b, 1'b0);
            apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        push_exp("gap_pre_lock", 0, 0, 0, 0, 0);
        check_output();
        next_prbs(b);
        apply_stimulus(1'b1, b, 1'b0);
        push_exp("gap_lock", 1, 0, 0, 0, 0);
        check_output();
        apply_stimulus(1'b0, ~b, 1'b0);
        push_exp("gap_idle_hold", 1, 0, 0, 0, 0);
        check_output();
        send_clean(1);
        push_exp("gap_bit", 1, 0, 0, 1, 0);
        check_output();
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        push_exp("gap_idle_bit_hold", 1, 0, 0, 1, 0);
        check_output();

        send_bad(1'b1);
        push_exp("clear_vs_err", 1, 0, 1, 0, 0);
        check_output();
        for (int i = 0; i < 6; i++) send_bad(1'b0);
        push_exp("multi_err_pre", 1, 0, 1, 6, 6);
        check_output();
        send_bad(1'b1);
        push_exp("loss_vs_clear", 0, 0, 1, 0, 0);
        check_output();

        for (int i = 1; i <= 500; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            if (i % 100 == 0) begin
                push_exp($sformatf("zeros_%0d", i), 0, 0, 0, 0, 0);
                check_output();
            end
        end
        for (int i = 1; i <= 500; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0);
            if (i % 100 == 0) begin
                push_exp($sformatf("ones_%0d", i), 0, 0, 0, 0, 0);
                check_output();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
